// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC dot-product sequencer.
package mac_pkg;

  localparam int unsigned OPD_W    = 4;
  localparam int unsigned ACC_W    = 8;
  localparam int unsigned SHADOW_W = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CAPT  = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [OPD_W-1:0] a;
    logic [OPD_W-1:0] b;
  } opd_pair_t;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Operand-pair stream from upstream into the sequencer's FIFO.
interface mac_dot_sequencer_if;
  import mac_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OPD_W-1:0] in_a;
  logic [OPD_W-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);

endinterface

// File: rtl/mac_operand_fifo.sv
// Synchronous operand-pair FIFO; pointers carry a wrap bit to tell full from empty.
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  opd_pair_t din,
  output logic      full,
  output logic      empty,
  output opd_pair_t dout
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  opd_pair_t        mem [DEPTH];
  logic [PTR_W:0]   wr_q;
  logic [PTR_W:0]   rd_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                 (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign dout  = mem[rd_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + (PTR_W+1)'(1);
      if (pop && !empty) rd_q <= rd_q + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeds buffered nibble pairs to the 4x4 MAC stage and captures the finished dot product.
// Optional overflow flag built when MAC_SEQ_OVF_EN is defined.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  mac_dot_sequencer_if.slave opd,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  output logic [OPD_W-1:0]  mac_a,
  output logic [OPD_W-1:0]  mac_b,
  output logic              mac_clr,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [OPD_W-1:0] mac_a_d, mac_b_d;
  logic [ACC_W-1:0] result_d;
  logic             done_d;
  logic             push, pop, fifo_full, fifo_empty;
  opd_pair_t        fifo_din, fifo_dout;

  assign fifo_din     = '{a: opd.in_a, b: opd.in_b};
  assign push         = opd.in_valid && !fifo_full;
  assign opd.in_ready = !fifo_full;

  mac_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // MAC clear tracks reset so both stages start from zero together.
  assign mac_clr = rst || (state_q == CLR);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    result_d    = result;
    done_d      = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = vec_len;
          state_d     = CLR;
        end
      end
      CLR:   state_d = (remaining_q == '0) ? DRAIN : RUN;
      // Empty FIFO issues zero operands, which leave the accumulator untouched.
      RUN: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          mac_a_d     = fifo_dout.a;
          mac_b_d     = fifo_dout.b;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: state_d = CAPT;
      CAPT: begin
        result_d = mac_acc;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      mac_a       <= '0;
      mac_b       <= '0;
      result      <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mac_a       <= mac_a_d;
      mac_b       <= mac_b_d;
      result      <= result_d;
      done        <= done_d;
    end
  end

`ifdef MAC_SEQ_OVF_EN
  // Full-precision shadow of the dot product to detect accumulator wrap.
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                ovf_q, ovf_d;

  always_comb begin
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    if (state_q == CLR) begin
      shadow_d = '0;
      ovf_d    = 1'b0;
    end else if (pop) begin
      shadow_d = shadow_q + SHADOW_W'(fifo_dout.a) * SHADOW_W'(fifo_dout.b);
    end
    if (state_q == CAPT) ovf_d = (shadow_q > SHADOW_W'(255));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioral 4x4 MAC accumulator attached.
module tb_mac_dot_sequencer;
  import mac_pkg::*;

`ifdef MAC_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vec_len;
  logic [3:0] mac_a, mac_b;
  logic       mac_clr, busy, done, ovf;
  logic [7:0] mac_acc, result;
  int         checks = 0;
  int         errors = 0;
  int         n;

  mac_dot_sequencer_if opd_if ();

  mac_dot_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .opd     (opd_if),
    .start   (start),
    .vec_len (vec_len),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_clr (mac_clr),
    .mac_acc (mac_acc),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Downstream MAC stage: registered accumulator, cleared by mac_clr.
  always @(posedge clk) begin
    if (mac_clr) mac_acc <= '0;
    else         mac_acc <= mac_acc + 8'(mac_a) * 8'(mac_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    opd_if.in_valid = 1'b1;
    opd_if.in_a     = a;
    opd_if.in_b     = b;
    tick();
    opd_if.in_valid = 1'b0;
  endtask

  task automatic go(input logic [3:0] len);
    start   = 1'b1;
    vec_len = len;
    tick();
    start   = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen, bounded.
  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    vec_len = '0;
    opd_if.in_valid = 1'b0;
    opd_if.in_a = '0;
    opd_if.in_b = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_mac_a", 32'(mac_a), 0);
    check("rst_in_ready", 32'(opd_if.in_ready), 1);
    check("rst_mac_clr", 32'(mac_clr), 1);
    check("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    tick();
    check("post_rst_mac_clr", 32'(mac_clr), 0);
    check("post_rst_busy", 32'(busy), 0);

    // Basic dot product: 15 + 14 + 225 = 254, cycle-by-cycle issue
    push(4'd3, 4'd5);
    push(4'd2, 4'd7);
    push(4'd15, 4'd15);
    go(4'd3);
    check("b_clr", 32'(mac_clr), 1);
    check("b_busy", 32'(busy), 1);
    tick();
    check("b_run_idle_opd", 32'(mac_a), 0);
    check("b_run_clr_low", 32'(mac_clr), 0);
    tick();
    check("b_issue0", 32'({mac_a, mac_b}), 32'h35);
    tick();
    check("b_issue1", 32'({mac_a, mac_b}), 32'h27);
    tick();
    check("b_issue2", 32'({mac_a, mac_b}), 32'hff);
    tick();
    check("b_drain_opd", 32'(mac_a), 0);
    check("b_drain_done", 32'(done), 0);
    tick();
    check("b_done", 32'(done), 1);
    check("b_result", 32'(result), 254);
    check("b_ovf", 32'(ovf), 0);
    tick();
    check("b_done_pulse", 32'(done), 0);
    check("b_result_hold", 32'(result), 254);
    check("b_idle", 32'(busy), 0);

    // Overflow: 225 + 225 = 450 -> 194
    push(4'd15, 4'd15);
    push(4'd15, 4'd15);
    go(4'd2);
    wait_done(20, n);
    check("o_latency", 32'(n), 5);
    check("o_result", 32'(result), 194);
    check("o_ovf", 32'(ovf), 32'(OVF_ON));
    tick();
    check("o_ovf_hold", 32'(ovf), 32'(OVF_ON));

    // Zero length with a queued pair that must not be consumed
    push(4'd4, 4'd4);
    go(4'd0);
    wait_done(20, n);
    check("z_latency", 32'(n), 3);
    check("z_result", 32'(result), 0);
    check("z_ovf_cleared", 32'(ovf), 0);
    tick();
    go(4'd1);
    wait_done(20, n);
    check("z_kept_pair", 32'(result), 16);
    tick();

    // Backpressure then starvation: 2+12+30+56+81 = 181
    push(4'd1, 4'd2);
    push(4'd3, 4'd4);
    push(4'd5, 4'd6);
    push(4'd7, 4'd8);
    check("bp_full", 32'(opd_if.in_ready), 0);
    push(4'd13, 4'd13);
    go(4'd5);
    tick();
    tick();
    check("bp_ready_after_pop", 32'(opd_if.in_ready), 1);
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_stall_opd", 32'({mac_a, mac_b}), 0);
      check("st_stall_busy", 32'(busy), 1);
    end
    push(4'd9, 4'd9);
    wait_done(20, n);
    check("st_done_seen", 32'(done), 1);
    check("st_result", 32'(result), 181);
    tick();

    // Reset mid-RUN after two of four pairs issued
    push(4'd1, 4'd1);
    push(4'd2, 4'd2);
    push(4'd3, 4'd3);
    push(4'd4, 4'd4);
    go(4'd4);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mr_mac_clr", 32'(mac_clr), 1);
    check("mr_busy", 32'(busy), 0);
    check("mr_result", 32'(result), 0);
    check("mr_in_ready", 32'(opd_if.in_ready), 1);
    check("mr_mac_a", 32'(mac_a), 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mr_no_done", 32'(done), 0);
    end
    push(4'd6, 4'd7);
    go(4'd1);
    wait_done(20, n);
    check("mr_latency", 32'(n), 4);
    check("mr_clean_result", 32'(result), 42);
    tick();

    // Back-to-back: 6 + 20 = 26, then 100 started in the done cycle
    push(4'd2, 4'd3);
    push(4'd4, 4'd5);
    push(4'd10, 4'd10);
    go(4'd2);
    wait_done(20, n);
    check("bb_latency0", 32'(n), 5);
    check("bb_result0", 32'(result), 26);
    check("bb_ovf0", 32'(ovf), 0);
    go(4'd1);
    check("bb_accepted", 32'(mac_clr), 1);
    wait_done(20, n);
    check("bb_latency1", 32'(n), 4);
    check("bb_result1", 32'(result), 100);
    tick();
    check("bb_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
